// File: rtl/universal_shift_register_pkg.sv
// Shared definitions for the universal shift register: the operation
// encoding, the burst controller state type and a burst-mode qualifier.
package usr_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_SAR   = 3'b011,
    MODE_ROL   = 3'b100,
    MODE_ROR   = 3'b101,
    MODE_LOAD  = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Only the five shift/rotate operations make sense to repeat in a burst.
  function automatic logic is_burst_mode(input logic [2:0] mode);
    return (mode >= MODE_SHL) && (mode <= MODE_ROR);
  endfunction

endpackage

// File: rtl/universal_shift_register_if.sv
// Bundles the operation, burst and observation signals of the shift
// register; master drives operations, slave is the register side.
interface universal_shift_register_if #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int CNT_W = 8
);

  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] load_data;
  logic [STEP-1:0]  serial_in;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] data_out;
  logic [STEP-1:0]  shift_out_msb;
  logic [STEP-1:0]  shift_out_lsb;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, load_data, serial_in, start, count,
    input  data_out, shift_out_msb, shift_out_lsb, busy, done
  );

  modport slave (
    input  en, mode, load_data, serial_in, start, count,
    output data_out, shift_out_msb, shift_out_lsb, busy, done
  );

endinterface

// File: rtl/universal_shift_register_shift_step_unit.sv
// Combinational next-value function of the register: one operation of
// the given mode applied to the current contents.
module shift_step_unit
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] load_i,
  input  logic [STEP-1:0]  serial_i,
  output logic [WIDTH-1:0] r_next_o
);

  // Select the next register value for the requested operation.
  always_comb begin
    r_next_o = r_i;
    case (mode_i)
      MODE_HOLD:  r_next_o = r_i;
      MODE_SHL:   r_next_o = {r_i[WIDTH-1-STEP:0], serial_i};
      MODE_SHR:   r_next_o = {serial_i, r_i[WIDTH-1:STEP]};
      MODE_SAR:   r_next_o = {{STEP{r_i[WIDTH-1]}}, r_i[WIDTH-1:STEP]};
      MODE_ROL:   r_next_o = {r_i[WIDTH-1-STEP:0], r_i[WIDTH-1 -: STEP]};
      MODE_ROR:   r_next_o = {r_i[STEP-1:0], r_i[WIDTH-1:STEP]};
      MODE_LOAD:  r_next_o = load_i;
      MODE_CLEAR: r_next_o = '0;
      default:    r_next_o = r_i;
    endcase
  end

endmodule

// File: rtl/universal_shift_register.sv
// Universal shift register with single-operation and counted-burst modes.
//
// state | meaning
// IDLE  | accepts en (one op) or start (burst request)
// RUN   | applies captured mode once per cycle, counting down
// DONE  | one-cycle completion pulse, then back to IDLE
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] load_data,
  input  logic [STEP-1:0]  serial_in,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] data_out,
  output logic [STEP-1:0]  shift_out_msb,
  output logic [STEP-1:0]  shift_out_lsb,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [2:0]       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]       op_sel;
  logic [WIDTH-1:0] r_step;

  // The single step unit serves both paths: live mode in IDLE, captured mode in RUN.
  assign op_sel = (state_q == ST_RUN) ? mode_q : mode;

  shift_step_unit #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .mode_i   (op_sel),
    .r_i      (r_q),
    .load_i   (load_data),
    .serial_i (serial_in),
    .r_next_o (r_step)
  );

  // Register update with synchronous reset overriding everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      mode_q  <= MODE_HOLD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and register next-value selection.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start && is_burst_mode(mode)) begin
          // Accept edge only captures; the first shift happens in RUN.
          mode_d  = mode;
          cnt_d   = count;
          state_d = (count == '0) ? ST_DONE : ST_RUN;
        end else if (en) begin
          r_d = r_step;
        end
      end
      ST_RUN: begin
        r_d = r_step;
        // Remaining count is never zero in RUN, so this cannot wrap.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign data_out      = r_q;
  assign shift_out_msb = r_q[WIDTH-1 -: STEP];
  assign shift_out_lsb = r_q[STEP-1:0];
  assign busy          = (state_q == ST_RUN);
  assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register (WIDTH=8, STEP=1): stimulus
// pushes the hand-computed post-edge observation into a scoreboard queue;
// a monitor pops and compares after every rising edge.
module tb_universal_shift_register;
  import usr_pkg::*;

  localparam int WIDTH = 8;
  localparam int STEP  = 1;
  localparam int CNT_W = 8;

  typedef struct {
    string      name;
    int         cyc;
    logic [7:0] data;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  universal_shift_register_if #(.WIDTH(WIDTH), .STEP(STEP), .CNT_W(CNT_W)) bus ();

  universal_shift_register #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (rst),
    .en            (bus.en),
    .mode          (bus.mode),
    .load_data     (bus.load_data),
    .serial_in     (bus.serial_in),
    .start         (bus.start),
    .count         (bus.count),
    .data_out      (bus.data_out),
    .shift_out_msb (bus.shift_out_msb),
    .shift_out_lsb (bus.shift_out_lsb),
    .busy          (bus.busy),
    .done          (bus.done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to tag expected observations.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due at this edge.
  always @(posedge clk) begin
    exp_t e;
    #2;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      n_checks++;
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
      end else if (bus.data_out !== e.data || bus.busy !== e.busy || bus.done !== e.done ||
                   bus.shift_out_msb !== e.data[7] || bus.shift_out_lsb !== e.data[0]) begin
        n_fail++;
        $display("FAIL %s: got data=%02h busy=%b done=%b msb=%b lsb=%b, want data=%02h busy=%b done=%b msb=%b lsb=%b",
                 e.name, bus.data_out, bus.busy, bus.done, bus.shift_out_msb, bus.shift_out_lsb,
                 e.data, e.busy, e.done, e.data[7], e.data[0]);
      end
    end
  end

  task automatic apply(input logic r, input logic e, input logic [2:0] md, input logic [7:0] ld,
                       input logic sin, input logic st, input logic [7:0] cnt);
    @(negedge clk);
    rst           = r;
    bus.en        = e;
    bus.mode      = md;
    bus.load_data = ld;
    bus.serial_in = sin;
    bus.start     = st;
    bus.count     = cnt;
  endtask

  task automatic chk(input string nm, input logic [7:0] d, input logic b, input logic dn);
    exp_t e;
    e.name = nm;
    e.cyc  = cyc + 1;
    e.data = d;
    e.busy = b;
    e.done = dn;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.mode      = MODE_HOLD;
    bus.load_data = '0;
    bus.serial_in = '0;
    bus.start     = 1'b0;
    bus.count     = '0;

    // Reset, including reset overriding a LOAD of 0xFF.
    apply(1'b1, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 8'd0);  chk("reset",        8'h00, 0, 0);
    apply(1'b1, 1'b1, MODE_LOAD, 8'hFF, 1'b0, 1'b0, 8'd0);  chk("rst_over_load", 8'h00, 0, 0);

    // Single operations.
    apply(1'b0, 1'b1, MODE_LOAD, 8'hA5, 1'b0, 1'b0, 8'd0);  chk("load_a5",  8'hA5, 0, 0);
    apply(1'b0, 1'b1, MODE_SHL,  8'h00, 1'b1, 1'b0, 8'd0);  chk("shl_sin1", 8'h4B, 0, 0);
    apply(1'b0, 1'b1, MODE_SHR,  8'h00, 1'b0, 1'b0, 8'd0);  chk("shr_sin0", 8'h25, 0, 0);
    apply(1'b0, 1'b0, MODE_SHL,  8'h00, 1'b1, 1'b0, 8'd0);  chk("en0_hold", 8'h25, 0, 0);
    apply(1'b0, 1'b1, MODE_HOLD, 8'hFF, 1'b1, 1'b0, 8'd0);  chk("mode_hold", 8'h25, 0, 0);
    apply(1'b0, 1'b1, MODE_LOAD, 8'h80, 1'b0, 1'b0, 8'd0);  chk("load_80",  8'h80, 0, 0);
    apply(1'b0, 1'b1, MODE_SAR,  8'h00, 1'b0, 1'b0, 8'd0);  chk("sar_80",   8'hC0, 0, 0);
    apply(1'b0, 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0, 8'd0);  chk("load_81a", 8'h81, 0, 0);
    apply(1'b0, 1'b1, MODE_ROL,  8'h00, 1'b0, 1'b0, 8'd0);  chk("rol_81",   8'h03, 0, 0);
    apply(1'b0, 1'b1, MODE_LOAD, 8'h81, 1'b0, 1'b0, 8'd0);  chk("load_81b", 8'h81, 0, 0);
    apply(1'b0, 1'b1, MODE_ROR,  8'h00, 1'b0, 1'b0, 8'd0);  chk("ror_81",   8'hC0, 0, 0);
    apply(1'b0, 1'b1, MODE_CLEAR, 8'h00, 1'b0, 1'b0, 8'd0); chk("clear",    8'h00, 0, 0);

    // Basic burst: ROL x3 from 0x01.
    apply(1'b0, 1'b1, MODE_LOAD, 8'h01, 1'b0, 1'b0, 8'd0);  chk("load_01",  8'h01, 0, 0);
    apply(1'b0, 1'b0, MODE_ROL,  8'h00, 1'b0, 1'b1, 8'd3);  chk("rol3_acc", 8'h01, 1, 0);
    idle();                                                 chk("rol3_s1",  8'h02, 1, 0);
    idle();                                                 chk("rol3_s2",  8'h04, 1, 0);
    idle();                                                 chk("rol3_done", 8'h08, 0, 1);
    idle();                                                 chk("rol3_idle", 8'h08, 0, 0);

    // count=0: straight to DONE, no shift, no busy.
    apply(1'b0, 1'b1, MODE_LOAD, 8'h5A, 1'b0, 1'b0, 8'd0);  chk("load_5a",   8'h5A, 0, 0);
    apply(1'b0, 1'b0, MODE_SHL,  8'h00, 1'b1, 1'b1, 8'd0);  chk("cnt0_done", 8'h5A, 0, 1);
    idle();                                                 chk("cnt0_idle", 8'h5A, 0, 0);

    // start with LOAD is ignored; en applies the LOAD normally.
    apply(1'b0, 1'b1, MODE_LOAD, 8'h3C, 1'b0, 1'b1, 8'd4);  chk("start_load_ign", 8'h3C, 0, 0);
    idle();                                                 chk("start_load_idle", 8'h3C, 0, 0);

    // start+en with SHL: burst accepted, no shift on accept; en/start ignored while busy/done.
    apply(1'b0, 1'b1, MODE_SHL,   8'h00, 1'b1, 1'b1, 8'd2); chk("shl2_acc",  8'h3C, 1, 0);
    apply(1'b0, 1'b1, MODE_CLEAR, 8'h00, 1'b1, 1'b1, 8'd9); chk("shl2_s1",   8'h79, 1, 0);
    apply(1'b0, 1'b1, MODE_LOAD,  8'hFF, 1'b0, 1'b1, 8'd9); chk("shl2_done", 8'hF2, 0, 1);
    apply(1'b0, 1'b1, MODE_CLEAR, 8'h00, 1'b0, 1'b1, 8'd9); chk("done_ign",  8'hF2, 0, 0);

    // Reset during cycle 2 of a count=5 burst aborts without done.
    apply(1'b0, 1'b1, MODE_LOAD, 8'h01, 1'b0, 1'b0, 8'd0);  chk("load_01b",  8'h01, 0, 0);
    apply(1'b0, 1'b0, MODE_ROL,  8'h00, 1'b0, 1'b1, 8'd5);  chk("rol5_acc",  8'h01, 1, 0);
    idle();                                                 chk("rol5_s1",   8'h02, 1, 0);
    apply(1'b1, 1'b0, MODE_HOLD, 8'h00, 1'b0, 1'b0, 8'd0);  chk("rol5_rst",  8'h00, 0, 0);
    idle();                                                 chk("rst_nodone1", 8'h00, 0, 0);
    idle();                                                 chk("rst_nodone2", 8'h00, 0, 0);
    apply(1'b0, 1'b1, MODE_LOAD, 8'h77, 1'b0, 1'b0, 8'd0);  chk("resume_load", 8'h77, 0, 0);
    idle();

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(negedge clk);
    while (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: never observed, want data=%02h busy=%b done=%b", e.name, e.data, e.busy, e.done);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
